// File: rtl/if_fetch_unit_if.sv
// Decode-side handshake bundle for the instruction-fetch front end.
// The fetch unit is the master: it offers {pc, instr} with id_valid,
// and decode (slave) accepts with id_ready.
interface if_fetch_unit_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    output id_valid,
    output id_pc,
    output id_instr,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_pc,
    input  id_instr,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, combinational instruction-memory
// address, small prefetch FIFO of {pc, instr} feeding decode, and redirect
// (branch/jump/trap) handling that flushes the FIFO.
// Optional feature macro: IF_MISALIGN_CHK_EN -- when defined, a redirect to a
// non-word-aligned target raises a sticky misalign flag and blocks fetch until
// the next aligned redirect; when undefined, targets are word-aligned by
// dropping the low two bits and the misalign outputs are tied to zero.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   halt_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [31:0]            iaddr_o,
  input  logic [31:0]            instr_i,
  if_fetch_unit_if.master        id_bus,
  output logic                   misalign_o,
  output logic [31:0]            misalign_addr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  // Prefetch storage and bookkeeping
  logic [63:0]   fifo_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pc_q, pc_d;

  logic          push, pop, fifo_nempty;
  logic          fetch_blk;
  logic [31:0]   redirect_tgt;

  assign iaddr_o     = pc_q;
  assign fifo_nempty = (count_q != '0);

  // Head presentation: a redirect kills whatever head is shown this cycle
  assign id_bus.id_valid = fifo_nempty & ~redirect_i;
  assign id_bus.id_pc    = fifo_nempty ? fifo_q[rd_q][63:32] : 32'h0;
  assign id_bus.id_instr = fifo_nempty ? fifo_q[rd_q][31:0]  : 32'h0;

  assign pop  = id_bus.id_valid & id_bus.id_ready;
  // A full FIFO may still accept a push when the head leaves the same cycle
  assign push = ~redirect_i & ~halt_i & ~fetch_blk & ((count_q < DEPTH_C) | pop);

`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_blk_q;
  logic        misalign_q;
  logic [31:0] misalign_addr_q;

  assign fetch_blk       = fetch_blk_q;
  assign redirect_tgt    = redirect_pc_i;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  // Sticky misalign tracking: set by an unaligned redirect, cleared by an aligned one
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_blk_q     <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else if (redirect_i) begin
      if (redirect_pc_i[1:0] != 2'b00) begin
        fetch_blk_q     <= 1'b1;
        misalign_q      <= 1'b1;
        misalign_addr_q <= redirect_pc_i;
      end else begin
        fetch_blk_q     <= 1'b0;
        misalign_q      <= 1'b0;
      end
    end
  end
`else
  logic unused_low_bits;

  // Targets are forced to word alignment; the low bits carry no meaning here
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign fetch_blk       = 1'b0;
  assign redirect_tgt    = {redirect_pc_i[31:2], 2'b00};
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = 32'h0;
`endif

  // Next-state for PC, pointers and occupancy; redirect overrides everything
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect_i) begin
      pc_d    = redirect_tgt;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // FIFO payload write; contents are only observed through count, so no clear needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_q] <= {pc_q, instr_i};
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming fetch, back-pressure, redirect
// flush and latency, PC wrap, halt/drain, misaligned targets and async reset.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        misalign;
  logic [31:0] misalign_addr;

  int n_vec;
  int n_err;

  if_fetch_unit_if id_bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .halt_i          (halt),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .iaddr_o         (iaddr),
    .instr_i         (instr),
    .id_bus          (id_bus),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed instruction memory image, little-endian word assembly
  function automatic logic [7:0] im_byte(input logic [31:0] a);
    return (a[7:0] * 8'd13 + 8'd7) ^ a[15:8];
  endfunction

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {im_byte(a + 32'd3), im_byte(a + 32'd2), im_byte(a + 32'd1), im_byte(a)};
  endfunction

  assign instr = im_word(iaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge, well away from the active edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    id_bus.id_ready = rdy;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    id_bus.id_ready = 1'b1;
    rst_n = 1'b0;

    // 1: reset state, then streaming fetch 0,4,8,12
    #2;
    check("rst_valid", {31'd0, id_bus.id_valid}, 32'd0);
    check("rst_pc", id_bus.id_pc, 32'h0);
    check("rst_instr", id_bus.id_instr, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_misaddr", misalign_addr, 32'h0);
    do_reset(1'b1);
    sample();
    check("t1_valid_pre", {31'd0, id_bus.id_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      check("t1_valid", {31'd0, id_bus.id_valid}, 32'd1);
      check("t1_pc", id_bus.id_pc, 32'(4 * k));
      check("t1_instr", id_bus.id_instr, im_word(32'(4 * k)));
    end

    // 2: back-pressure fills the FIFO, then push+pop with full FIFO
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) tick();
    sample();
    check("t2_valid", {31'd0, id_bus.id_valid}, 32'd1);
    check("t2_head_pc", id_bus.id_pc, 32'h0);
    check("t2_head_instr", id_bus.id_instr, im_word(32'h0));
    check("t2_iaddr", iaddr, 32'h8);
    id_bus.id_ready = 1'b1;
    tick();
    id_bus.id_ready = 1'b0;
    sample();
    check("t2_pp_pc", id_bus.id_pc, 32'h4);
    check("t2_pp_iaddr", iaddr, 32'hC);
    tick();
    sample();
    check("t2_full_iaddr", iaddr, 32'hC);
    check("t2_full_pc", id_bus.id_pc, 32'h4);

    // 3: redirect with full FIFO kills head, target appears at N+2
    id_bus.id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    sample();
    check("t3_valid_n", {31'd0, id_bus.id_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    sample();
    check("t3_valid_n1", {31'd0, id_bus.id_valid}, 32'd0);
    check("t3_iaddr_n1", iaddr, 32'h100);
    tick();
    sample();
    check("t3_valid_n2", {31'd0, id_bus.id_valid}, 32'd1);
    check("t3_pc_n2", id_bus.id_pc, 32'h100);
    check("t3_instr_n2", id_bus.id_instr, im_word(32'h100));

    // 4: PC wraps past the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    sample();
    check("t4_pc0", id_bus.id_pc, 32'hFFFF_FFF8);
    check("t4_instr0", id_bus.id_instr, im_word(32'hFFFF_FFF8));
    tick();
    sample();
    check("t4_pc1", id_bus.id_pc, 32'hFFFF_FFFC);
    tick();
    sample();
    check("t4_pc2", id_bus.id_pc, 32'h0000_0000);
    check("t4_instr2", id_bus.id_instr, im_word(32'h0));

    // 5: halt drains the FIFO and holds PC; redirect during halt still loads PC
    id_bus.id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    id_bus.id_ready = 1'b1;
    sample();
    check("t5_head0", id_bus.id_pc, 32'h40);
    check("t5_iaddr0", iaddr, 32'h48);
    tick();
    sample();
    check("t5_head1", id_bus.id_pc, 32'h44);
    tick();
    sample();
    check("t5_drained", {31'd0, id_bus.id_valid}, 32'd0);
    tick();
    sample();
    check("t5_still_empty", {31'd0, id_bus.id_valid}, 32'd0);
    check("t5_pc_held", iaddr, 32'h48);
    halt = 1'b0;
    tick();
    sample();
    check("t5_resume_valid", {31'd0, id_bus.id_valid}, 32'd1);
    check("t5_resume_pc", id_bus.id_pc, 32'h48);
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    sample();
    check("t5_hr_iaddr", iaddr, 32'h80);
    check("t5_hr_valid", {31'd0, id_bus.id_valid}, 32'd0);
    tick();
    sample();
    check("t5_hr_hold", iaddr, 32'h80);
    check("t5_hr_nopush", {31'd0, id_bus.id_valid}, 32'd0);
    halt = 1'b0;
    tick();
    sample();
    check("t5_hr_pc", id_bus.id_pc, 32'h80);

    // 6: misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    sample();
`ifdef IF_MISALIGN_CHK_EN
    check("t6_mis", {31'd0, misalign}, 32'd1);
    check("t6_misaddr", misalign_addr, 32'h102);
    check("t6_iaddr", iaddr, 32'h102);
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      check("t6_blocked", {31'd0, id_bus.id_valid}, 32'd0);
      check("t6_mis_sticky", {31'd0, misalign}, 32'd1);
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    sample();
    check("t6_mis_clr", {31'd0, misalign}, 32'd0);
    tick();
    sample();
    check("t6_resume_pc", id_bus.id_pc, 32'h200);
`else
    check("t6_mis", {31'd0, misalign}, 32'd0);
    check("t6_misaddr", misalign_addr, 32'h0);
    check("t6_iaddr", iaddr, 32'h100);
    tick();
    sample();
    check("t6_valid", {31'd0, id_bus.id_valid}, 32'd1);
    check("t6_pc", id_bus.id_pc, 32'h100);
`endif

    // 7: asynchronous reset mid-operation clears state immediately
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_valid", {31'd0, id_bus.id_valid}, 32'd0);
    check("t7_iaddr", iaddr, 32'h0);
    check("t7_pc", id_bus.id_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    sample();
    check("t7_restart_pc", id_bus.id_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
